// File: rtl/kmeans_job_sequencer_pkg.sv
// Shared types and sizing for the k-means job sequencer slice.
// Holds the job descriptor carried through the job FIFO and the
// sequencer state encoding, plus the widths every other file agrees on.
package kmeans_job_sequencer_pkg;

   localparam int addrWidth       = 9;
   localparam int manhatten_width = 16;
   localparam int job_depth       = 4;
   localparam int log2_job_depth  = 2;
   localparam int timeout_width   = 20;

   // One queued job: an inclusive RAM window plus its convergence threshold.
   typedef struct packed {
      logic [addrWidth-1:0]       first;
      logic [addrWidth-1:0]       last;
      logic [manhatten_width-1:0] thresh;
   } job_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GO,
      WAIT,
      DONE,
      ERR
   } seq_state_e;

endpackage

// File: rtl/kmeans_job_sequencer_if.sv
// Job submission bus between the host register file and the sequencer.
// master (host side): drives job_push/job_first/job_last/job_thresh,
//                     observes job_full/job_count/job_reject.
// slave  (sequencer): the reverse.
interface kmeans_job_sequencer_if;
   import kmeans_job_sequencer_pkg::*;

   logic                       job_push;
   logic [addrWidth-1:0]       job_first;
   logic [addrWidth-1:0]       job_last;
   logic [manhatten_width-1:0] job_thresh;
   logic                       job_full;
   logic [log2_job_depth:0]    job_count;
   logic                       job_reject;

   modport master (
      output job_push, job_first, job_last, job_thresh,
      input  job_full, job_count, job_reject
   );

   modport slave (
      input  job_push, job_first, job_last, job_thresh,
      output job_full, job_count, job_reject
   );

endinterface

// File: rtl/kmeans_job_sequencer_fifo.sv
// kmeans_job_fifo: small synchronous FIFO of job_t descriptors.
// Ports: clk, rst (sync, active-high); push/pop (caller-qualified, never
// push when full nor pop when empty); flush empties the queue; pushData in,
// headData is the current head (combinational read); full and count out.
module kmeans_job_fifo
   import kmeans_job_sequencer_pkg::*;
#(
   parameter int depth     = job_depth,
   parameter int log2Depth = log2_job_depth
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  job_t               pushData,
   output job_t               headData,
   output logic               full,
   output logic [log2Depth:0] count
);

   job_t                 mem_q [depth];
   logic [log2Depth-1:0] wrPtr_q;
   logic [log2Depth-1:0] rdPtr_q;
   logic [log2Depth:0]   count_q;

   // Pointer and occupancy bookkeeping. A flush that coincides with a push
   // keeps the new entry, so the freshly pushed job lands in slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (flush) begin
         rdPtr_q <= '0;
         wrPtr_q <= push ? log2Depth'(1) : '0;
         count_q <= push ? (log2Depth + 1)'(1) : '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + log2Depth'(1);
         if (pop)  rdPtr_q <= rdPtr_q + log2Depth'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (log2Depth + 1)'(1);
            2'b01:   count_q <= count_q - (log2Depth + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; no reset needed since count_q gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[flush ? '0 : wrPtr_q] <= pushData;
   end

   assign headData = mem_q[rdPtr_q];
   assign full     = (count_q == (log2Depth + 1)'(depth));
   assign count    = count_q;

endmodule

// File: rtl/kmeans_job_sequencer.sv
// kmeans_job_sequencer: queues k-means jobs and launches the core one job
// at a time, waiting for its completion interrupt under an optional timeout.
// Ports: clk, rst (sync, active-high); jobIf (slave job bus: push, window,
// threshold, full/count/reject status); seq_enable, abort, err_clr,
// timeout_cycles controls; go_core plus held window/threshold to the core;
// core_done from the core; busy, job_done, job_error, jobs_completed status.
module kmeans_job_sequencer
   import kmeans_job_sequencer_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   kmeans_job_sequencer_if.slave      jobIf,
   input  logic                       seq_enable,
   input  logic                       abort,
   input  logic                       err_clr,
   input  logic [timeout_width-1:0]   timeout_cycles,
   output logic                       go_core,
   output logic [addrWidth-1:0]       first_ram_address,
   output logic [addrWidth-1:0]       last_ram_address,
   output logic [manhatten_width-1:0] threshold_value,
   input  logic                       core_done,
   output logic                       busy,
   output logic                       job_done,
   output logic                       job_error,
   output logic [7:0]                 jobs_completed
);

   seq_state_e               state_q;
   logic [timeout_width-1:0] timer_q;
   logic                     rejectPulse_q;

   job_t                     pushJob;
   job_t                     headJob;
   logic                     fifoFull;
   logic [log2_job_depth:0]  fifoCount;
   logic                     pushReq;
   logic                     pushAccept;
   logic                     startJob;
   logic                     fifoFlush;
   logic                     timeoutHit;

   // Abort swallows a same-cycle push silently, so it never reaches the
   // accept/reject decision. Fullness is judged before any same-cycle pop.
   assign pushReq    = jobIf.job_push && !abort;
   assign pushAccept = pushReq && !fifoFull && (jobIf.job_first <= jobIf.job_last);
   assign startJob   = (state_q == IDLE) && seq_enable && (fifoCount != '0) &&
                       !job_error && !abort;
   assign fifoFlush  = abort || (state_q == ERR);
   assign timeoutHit = (timeout_cycles != '0) &&
                       (timer_q == timeout_cycles - timeout_width'(1));

   assign pushJob.first  = jobIf.job_first;
   assign pushJob.last   = jobIf.job_last;
   assign pushJob.thresh = jobIf.job_thresh;

   kmeans_job_fifo #(
      .depth     (job_depth),
      .log2Depth (log2_job_depth)
   ) jobFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (pushAccept),
      .pop      (startJob),
      .flush    (fifoFlush),
      .pushData (pushJob),
      .headData (headJob),
      .full     (fifoFull),
      .count    (fifoCount)
   );

   // Sequencer FSM with all status outputs registered. Abort overrides the
   // state walk but leaves the held window/threshold and completion count
   // alone. In WAIT a core_done is checked before the timeout so a finish
   // on the last allowed cycle still counts as success; the ERR write of
   // job_error comes after err_clr so a coincident set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         timer_q           <= '0;
         rejectPulse_q     <= 1'b0;
         go_core           <= 1'b0;
         first_ram_address <= '0;
         last_ram_address  <= '0;
         threshold_value   <= '0;
         job_done          <= 1'b0;
         job_error         <= 1'b0;
         jobs_completed    <= '0;
      end else begin
         go_core       <= 1'b0;
         job_done      <= 1'b0;
         rejectPulse_q <= pushReq && !pushAccept;
         if (err_clr) job_error <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (startJob) begin
                     state_q           <= LOAD;
                     first_ram_address <= headJob.first;
                     last_ram_address  <= headJob.last;
                     threshold_value   <= headJob.thresh;
                  end
               end
               LOAD: begin
                  state_q <= GO;
                  go_core <= 1'b1;
                  timer_q <= '0;
               end
               GO: begin
                  state_q <= WAIT;
               end
               WAIT: begin
                  timer_q <= timer_q + timeout_width'(1);
                  if (core_done) begin
                     state_q        <= DONE;
                     job_done       <= 1'b1;
                     jobs_completed <= jobs_completed + 8'd1;
                  end else if (timeoutHit) begin
                     state_q <= ERR;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               ERR: begin
                  job_error <= 1'b1;
                  state_q   <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy             = (state_q != IDLE);
   assign jobIf.job_full   = fifoFull;
   assign jobIf.job_count  = fifoCount;
   assign jobIf.job_reject = rejectPulse_q;

endmodule

// File: tb/tb_kmeans_job_sequencer.sv
// Directed testbench for kmeans_job_sequencer. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_kmeans_job_sequencer;
   import kmeans_job_sequencer_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       seq_enable;
   logic                       abort;
   logic                       err_clr;
   logic [timeout_width-1:0]   timeout_cycles;
   logic                       go_core;
   logic [addrWidth-1:0]       first_ram_address;
   logic [addrWidth-1:0]       last_ram_address;
   logic [manhatten_width-1:0] threshold_value;
   logic                       core_done;
   logic                       busy;
   logic                       job_done;
   logic                       job_error;
   logic [7:0]                 jobs_completed;

   int checkCount = 0;
   int errorCount = 0;

   kmeans_job_sequencer_if jobIf();

   kmeans_job_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .jobIf             (jobIf),
      .seq_enable        (seq_enable),
      .abort             (abort),
      .err_clr           (err_clr),
      .timeout_cycles    (timeout_cycles),
      .go_core           (go_core),
      .first_ram_address (first_ram_address),
      .last_ram_address  (last_ram_address),
      .threshold_value   (threshold_value),
      .core_done         (core_done),
      .busy              (busy),
      .job_done          (job_done),
      .job_error         (job_error),
      .jobs_completed    (jobs_completed)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present one job on the bus for exactly one rising edge.
   task automatic applyStimulus(input int first, input int last, input int thresh);
      jobIf.job_push   = 1'b1;
      jobIf.job_first  = addrWidth'(first);
      jobIf.job_last   = addrWidth'(last);
      jobIf.job_thresh = manhatten_width'(thresh);
      step(1);
      jobIf.job_push   = 1'b0;
   endtask

   // Step until go_core is seen (returns in the GO cycle) or the budget runs out.
   task automatic waitGo(input int maxCycles);
      bit seen = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         if (go_core) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      if (!seen) checkOutput("go_core_wait", 32'(seen), 32'd1);
   endtask

   // From the GO cycle: finish the job in the first WAIT cycle, then return to IDLE.
   task automatic completeJob(input int expectedCount);
      step(1);
      core_done = 1'b1;
      step(1);
      core_done = 1'b0;
      checkOutput("job_done", 32'(job_done), 32'd1);
      checkOutput("jobs_completed", 32'(jobs_completed), 32'(expectedCount & 255));
      step(1);
   endtask

   // Watch for n cycles and confirm no launch happens.
   task automatic expectNoGo(input string tag, input int n);
      bit seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (go_core) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      rst              = 1'b1;
      seq_enable       = 1'b0;
      abort            = 1'b0;
      err_clr          = 1'b0;
      timeout_cycles   = '0;
      core_done        = 1'b0;
      jobIf.job_push   = 1'b0;
      jobIf.job_first  = '0;
      jobIf.job_last   = '0;
      jobIf.job_thresh = '0;
      step(3);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_go_core", 32'(go_core), 32'd0);
      checkOutput("rst_first", 32'(first_ram_address), 32'd0);
      checkOutput("rst_last", 32'(last_ram_address), 32'd0);
      checkOutput("rst_thresh", 32'(threshold_value), 32'd0);
      checkOutput("rst_job_error", 32'(job_error), 32'd0);
      checkOutput("rst_jobs_completed", 32'(jobs_completed), 32'd0);
      checkOutput("rst_job_count", 32'(jobIf.job_count), 32'd0);
      checkOutput("rst_job_full", 32'(jobIf.job_full), 32'd0);
      checkOutput("rst_job_done", 32'(job_done), 32'd0);
      rst = 1'b0;
      step(1);

      // Single job: launch latency, held outputs, completion after 10 WAIT cycles.
      seq_enable = 1'b1;
      applyStimulus(0, 99, 5);
      checkOutput("t1_count_after_push", 32'(jobIf.job_count), 32'd1);
      checkOutput("t1_go_early1", 32'(go_core), 32'd0);
      step(1);
      checkOutput("t1_go_early2", 32'(go_core), 32'd0);
      checkOutput("t1_busy_load", 32'(busy), 32'd1);
      step(1);
      checkOutput("t1_go_core", 32'(go_core), 32'd1);
      checkOutput("t1_first", 32'(first_ram_address), 32'd0);
      checkOutput("t1_last", 32'(last_ram_address), 32'd99);
      checkOutput("t1_thresh", 32'(threshold_value), 32'd5);
      checkOutput("t1_count_popped", 32'(jobIf.job_count), 32'd0);
      step(1);
      checkOutput("t1_go_one_cycle", 32'(go_core), 32'd0);
      step(9);
      checkOutput("t1_no_done_yet", 32'(job_done), 32'd0);
      core_done = 1'b1;
      step(1);
      core_done = 1'b0;
      checkOutput("t1_job_done", 32'(job_done), 32'd1);
      checkOutput("t1_jobs_completed", 32'(jobs_completed), 32'd1);
      step(1);
      checkOutput("t1_done_pulse", 32'(job_done), 32'd0);
      checkOutput("t1_busy_idle", 32'(busy), 32'd0);
      checkOutput("t1_last_held", 32'(last_ram_address), 32'd99);

      // Fill the FIFO while disabled, overflow it, then drain four jobs in order.
      seq_enable = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(i * 10, i * 10 + 5, i + 1);
      checkOutput("t2_count_full", 32'(jobIf.job_count), 32'd4);
      checkOutput("t2_job_full", 32'(jobIf.job_full), 32'd1);
      checkOutput("t2_no_reject_yet", 32'(jobIf.job_reject), 32'd0);
      applyStimulus(200, 201, 9);
      checkOutput("t2_reject_full", 32'(jobIf.job_reject), 32'd1);
      checkOutput("t2_count_kept", 32'(jobIf.job_count), 32'd4);
      checkOutput("t2_disabled_idle", 32'(busy), 32'd0);
      step(1);
      checkOutput("t2_reject_pulse", 32'(jobIf.job_reject), 32'd0);
      seq_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         waitGo(10);
         checkOutput("t2_first", 32'(first_ram_address), 32'(i * 10));
         checkOutput("t2_last", 32'(last_ram_address), 32'(i * 10 + 5));
         checkOutput("t2_thresh", 32'(threshold_value), 32'(i + 1));
         completeJob(2 + i);
      end
      checkOutput("t2_drained", 32'(jobIf.job_count), 32'd0);

      // Inverted window is refused and never launches.
      applyStimulus(50, 10, 1);
      checkOutput("t3_reject_window", 32'(jobIf.job_reject), 32'd1);
      checkOutput("t3_count", 32'(jobIf.job_count), 32'd0);
      expectNoGo("t3_no_go", 6);
      checkOutput("t3_jobs_completed", 32'(jobs_completed), 32'd5);

      // Timeout after 8 WAIT cycles flushes the queue and latches the error.
      timeout_cycles = 20'd8;
      applyStimulus(1, 2, 3);
      waitGo(10);
      applyStimulus(20, 30, 4);
      applyStimulus(21, 31, 4);
      checkOutput("t4_queued", 32'(jobIf.job_count), 32'd2);
      step(6);
      checkOutput("t4_err_not_yet", 32'(job_error), 32'd0);
      checkOutput("t4_busy_wait8", 32'(busy), 32'd1);
      step(2);
      checkOutput("t4_job_error", 32'(job_error), 32'd1);
      checkOutput("t4_flushed", 32'(jobIf.job_count), 32'd0);
      checkOutput("t4_idle", 32'(busy), 32'd0);
      checkOutput("t4_no_job_done", 32'(jobs_completed), 32'd5);
      applyStimulus(5, 6, 7);
      checkOutput("t4_push_in_error", 32'(jobIf.job_count), 32'd1);
      expectNoGo("t4_blocked_by_error", 5);
      checkOutput("t4_still_queued", 32'(jobIf.job_count), 32'd1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      checkOutput("t4_err_clr", 32'(job_error), 32'd0);
      waitGo(10);
      checkOutput("t4_resume_first", 32'(first_ram_address), 32'd5);
      completeJob(6);

      // Abort in WAIT with two queued: flush, no completion, late core_done ignored.
      applyStimulus(100, 110, 2);
      waitGo(10);
      applyStimulus(40, 41, 1);
      applyStimulus(42, 43, 1);
      checkOutput("t5_queued", 32'(jobIf.job_count), 32'd2);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      checkOutput("t5_abort_idle", 32'(busy), 32'd0);
      checkOutput("t5_abort_flush", 32'(jobIf.job_count), 32'd0);
      checkOutput("t5_abort_no_done", 32'(job_done), 32'd0);
      checkOutput("t5_first_held", 32'(first_ram_address), 32'd100);
      core_done = 1'b1;
      step(1);
      core_done = 1'b0;
      checkOutput("t5_late_done_ignored", 32'(job_done), 32'd0);
      checkOutput("t5_jobs_completed", 32'(jobs_completed), 32'd6);
      expectNoGo("t5_no_go", 5);

      // core_done on the exact timeout cycle counts as success.
      applyStimulus(3, 4, 5);
      waitGo(10);
      step(8);
      core_done = 1'b1;
      step(1);
      core_done = 1'b0;
      checkOutput("t6_done_wins", 32'(job_done), 32'd1);
      checkOutput("t6_no_error", 32'(job_error), 32'd0);
      checkOutput("t6_jobs_completed", 32'(jobs_completed), 32'd7);
      step(2);
      checkOutput("t6_error_stays_clear", 32'(job_error), 32'd0);

      // Run the completion counter up to 255 and across the wrap.
      timeout_cycles = '0;
      for (int n = 0; n < 248; n++) begin
         applyStimulus(0, 10, 1);
         waitGo(10);
         completeJob(8 + n);
      end
      checkOutput("t7_count_255", 32'(jobs_completed), 32'd255);
      applyStimulus(0, 10, 1);
      waitGo(10);
      completeJob(0);
      checkOutput("t7_wrapped", 32'(jobs_completed), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
